// File: rtl/cpu_top.sv
// -----------------------------------------------------------------------------
// cpu_top -- single-cycle RV32I core (CPI = 1, no pipeline).
//
// Each cycle the word at i_mem_addr (== PC) is decoded, executed and committed
// on the next rising clk edge. Instruction and data memories are external
// and read combinationally in the same cycle.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset (PC <= RESET_PC, x1..x31 <= 0)
//   i_mem_addr   fetch byte address (the PC)
//   i_mem_rdata  instruction word for i_mem_addr
//   d_mem_addr   load/store byte address (rs1 + imm)
//   d_mem_wdata  store data, replicated across byte lanes
//   d_mem_wen    per-byte write enables, 0 unless a store is executing
//   d_mem_rdata  aligned word at d_mem_addr[31:2]
//
// Build option:
//   CPU_TOP_MUL_EN  when defined, MUL/MULH/MULHSU/MULHU are implemented.
//                   Otherwise those encodings (and DIV/REM always) are NOPs.
//
// regs_flat mirrors the register file (x0 slice is constant 0) and is also
// the read port used for rs1/rs2.
// -----------------------------------------------------------------------------
module cpu_top #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] d_mem_addr,
    output logic [31:0] d_mem_wdata,
    output logic [3:0]  d_mem_wen,
    input  logic [31:0] d_mem_rdata
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;
    // Memory fill pattern; it happens to decode as JAL, so it is trapped
    // explicitly and treated as an unrecognised encoding.
    localparam logic [31:0] FILL_WORD = 32'hdeadbeef;

    logic [31:0]   pc, next_pc;
    logic [31:0]   regs [1:31];
    logic [1023:0] regs_flat;

    logic [31:0] instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, addr_sum;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        rd_we, taken;
    logic [31:0] wb_data;
    logic [3:0]  wen_c;

    assign instr      = i_mem_rdata;
    assign opcode     = instr[6:0];
    assign rd         = instr[11:7];
    assign funct3     = instr[14:12];
    assign rs1        = instr[19:15];
    assign rs2        = instr[24:20];
    assign funct7     = instr[31:25];
    assign imm_i      = {{20{instr[31]}}, instr[31:20]};
    assign imm_s      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u      = {instr[31:12], 12'b0};
    assign imm_j      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        regs_flat[31:0] = '0;
        for (int i = 1; i < 32; i++) regs_flat[i*32 +: 32] = regs[i];
    end

    assign rs1_val    = regs_flat[{rs1, 5'b00000} +: 32];
    assign rs2_val    = regs_flat[{rs2, 5'b00000} +: 32];
    assign addr_sum   = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign i_mem_addr = pc;
    assign d_mem_addr = addr_sum;
    // Lane selection ignores straddles: a halfword at offset 3 reads lanes 3:2.
    assign byte_sel   = d_mem_rdata[{d_mem_addr[1:0], 3'b000} +: 8];
    assign half_sel   = d_mem_rdata[{d_mem_addr[1], 4'b0000} +: 16];
    assign d_mem_wen  = rst_n ? wen_c : 4'b0000;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'b0, $signed(a) < $signed(b)};
            3'd3:    r = {31'b0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

`ifdef CPU_TOP_MUL_EN
    // One 64-bit multiplier; operand extension picks signed/unsigned flavour
    // (MULH: both signed, MULHSU: rs1 signed, MULHU/MUL: zero-extended).
    logic [63:0] mul_a, mul_b, mul_p;
    always_comb begin
        mul_a = {{32{(funct3 == 3'd1 || funct3 == 3'd2) & rs1_val[31]}}, rs1_val};
        mul_b = {{32{(funct3 == 3'd1) & rs2_val[31]}}, rs2_val};
        mul_p = mul_a * mul_b;
    end
`endif

    always_comb begin
        case (funct3)
            3'd0:    taken = (rs1_val == rs2_val);
            3'd1:    taken = (rs1_val != rs2_val);
            3'd4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6:    taken = (rs1_val <  rs2_val);
            3'd7:    taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc     = pc + 32'd4;
        rd_we       = 1'b0;
        wb_data     = '0;
        wen_c       = 4'b0000;
        d_mem_wdata = '0;
        if (instr != FILL_WORD) begin
            case (opcode)
                OPC_LUI:   begin rd_we = 1'b1; wb_data = imm_u; end
                OPC_AUIPC: begin rd_we = 1'b1; wb_data = pc + imm_u; end
                OPC_JAL: begin
                    rd_we = 1'b1; wb_data = pc + 32'd4; next_pc = pc + imm_j;
                end
                OPC_JALR: if (funct3 == 3'd0) begin
                    rd_we = 1'b1; wb_data = pc + 32'd4; next_pc = {addr_sum[31:1], 1'b0};
                end
                OPC_BRANCH: if (taken) next_pc = pc + imm_b;
                OPC_LOAD: begin
                    rd_we = 1'b1;
                    case (funct3)
                        3'd0:    wb_data = {{24{byte_sel[7]}}, byte_sel};
                        3'd1:    wb_data = {{16{half_sel[15]}}, half_sel};
                        3'd2:    wb_data = d_mem_rdata;
                        3'd4:    wb_data = {24'b0, byte_sel};
                        3'd5:    wb_data = {16'b0, half_sel};
                        default: rd_we = 1'b0;
                    endcase
                end
                OPC_STORE: begin
                    case (funct3)
                        3'd0: begin
                            wen_c = 4'b0001 << addr_sum[1:0]; d_mem_wdata = {4{rs2_val[7:0]}};
                        end
                        3'd1: begin
                            wen_c = addr_sum[1] ? 4'b1100 : 4'b0011; d_mem_wdata = {2{rs2_val[15:0]}};
                        end
                        3'd2:    begin wen_c = 4'b1111; d_mem_wdata = rs2_val; end
                        default: wen_c = 4'b0000;
                    endcase
                end
                OPC_OPIMM: begin
                    // Only shift-immediates constrain funct7; SRAI is the sole alt form.
                    if ((funct3 == 3'd1 && funct7 == F7_ZERO) ||
                        (funct3 == 3'd5 && (funct7 == F7_ZERO || funct7 == F7_ALT)) ||
                        (funct3 != 3'd1 && funct3 != 3'd5)) begin
                        rd_we   = 1'b1;
                        wb_data = alu(funct3, (funct3 == 3'd5) & instr[30], rs1_val, imm_i);
                    end
                end
                OPC_OP: begin
                    if (funct7 == F7_ZERO ||
                        (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5))) begin
                        rd_we   = 1'b1;
                        wb_data = alu(funct3, instr[30], rs1_val, rs2_val);
                    end
`ifdef CPU_TOP_MUL_EN
                    else if (funct7 == F7_MULDIV && !funct3[2]) begin
                        rd_we   = 1'b1;
                        wb_data = (funct3 == 3'd0) ? mul_p[31:0] : mul_p[63:32];
                    end
`endif
                end
                default: rd_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else begin
            pc <= next_pc;
            if (rd_we && rd != 5'd0) regs[rd] <= wb_data;
        end
    end
endmodule

// File: tb/tb_cpu_top.sv
// -----------------------------------------------------------------------------
// tb_cpu_top -- self-checking bench for cpu_top.
// Directed vector table, hand sequences for control flow and mid-program
// reset, then a random program checked against an instruction-level model.
// -----------------------------------------------------------------------------
module tb_cpu_top;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef CPU_TOP_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] FILL = 32'hdeadbeef;
    localparam int RN = 150;

    // ---------------- clock / reset / memories ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] i_mem_addr, i_mem_rdata, d_mem_addr, d_mem_wdata, d_mem_rdata;
    logic [3:0]  d_mem_wen;
    logic [31:0] imem [256];
    logic [31:0] dmem [256];

    assign i_mem_rdata = imem[i_mem_addr[9:2]];
    assign d_mem_rdata = dmem[d_mem_addr[9:2]];
    always @(posedge clk)
        for (int b = 0; b < 4; b++)
            if (d_mem_wen[b]) dmem[d_mem_addr[9:2]][8*b +: 8] <= d_mem_wdata[8*b +: 8];

    cpu_top #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_addr(i_mem_addr), .i_mem_rdata(i_mem_rdata),
        .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
        .d_mem_wen(d_mem_wen), .d_mem_rdata(d_mem_rdata)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // ---------------- checking helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_flat(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_reg(input int idx);
        return dut.regs_flat[idx*32 +: 32];
    endfunction

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] ins_i(input int op, input int f3, input int rd, input int rs1, input int imm);
        logic [31:0] o, f, d, s, m;
        o = op; f = f3; d = rd; s = rs1; m = imm;
        return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] ins_r(input int f3, input int f7, input int rd, input int rs1, input int rs2);
        logic [31:0] f, g, d, s, t;
        f = f3; g = f7; d = rd; s = rs1; t = rs2;
        return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] ins_s(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] f, s, t, m;
        f = f3; s = rs1; t = rs2; m = imm;
        return {m[11:5], t[4:0], s[4:0], f[2:0], m[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] ins_b(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] f, s, t, m;
        f = f3; s = rs1; t = rs2; m = imm;
        return {m[12], m[10:5], t[4:0], s[4:0], f[2:0], m[4:1], m[11], 7'h63};
    endfunction
    function automatic logic [31:0] ins_u(input int op, input int rd, input int imm20);
        logic [31:0] o, d, m;
        o = op; d = rd; m = imm20;
        return {m[19:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] ins_j(input int rd, input int imm);
        logic [31:0] d, m;
        d = rd; m = imm;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return ins_i(7'h13, 0, rd, rs1, imm);
    endfunction

    // Called at the negedge: reset takes effect at the following posedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check32("rst_wen", {28'b0, d_mem_wen}, 32'h0);
        @(posedge clk); #1;
        check32("rst_pc", i_mem_addr, RESET_PC);
        check_flat("rst_regs", dut.regs_flat, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_dmem [256];

    function automatic logic [1023:0] model_flat();
        logic [1023:0] f;
        f = '0;
        for (int i = 1; i < 32; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    // Executes one instruction at ISA level on the model state.
    task automatic model_step(input logic [31:0] ins, output logic [3:0] e_wen,
                              output logic [31:0] e_wdata, output logic [31:0] e_addr);
        logic [31:0] a, b, res, nxt, ea, w, ii, is_, ib, ij;
        logic [63:0] p;
        logic        wr;
        int          v, op, f3, f7, rd;
        op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]); rd = int'(ins[11:7]);
        a  = m_regs[ins[19:15]];
        b  = m_regs[ins[24:20]];
        ii = {{20{ins[31]}}, ins[31:20]};
        is_ = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        nxt = m_pc + 4; wr = 0; res = 0; e_wen = 0; e_wdata = 0; e_addr = 0;
        if (ins != FILL) begin
            case (op)
                'h37: begin wr = 1; res = {ins[31:12], 12'b0}; end
                'h17: begin wr = 1; res = m_pc + {ins[31:12], 12'b0}; end
                'h6f: begin wr = 1; res = m_pc + 4; nxt = m_pc + ij; end
                'h67: if (f3 == 0) begin wr = 1; res = m_pc + 4; nxt = (a + ii) & 32'hffff_fffe; end
                'h63: begin
                    if ((f3 == 0 && a == b) || (f3 == 1 && a != b) ||
                        (f3 == 4 && int'(a) < int'(b)) || (f3 == 5 && int'(a) >= int'(b)) ||
                        (f3 == 6 && a < b) || (f3 == 7 && a >= b))
                        nxt = m_pc + ib;
                end
                'h03: begin
                    ea = a + ii; w = m_dmem[ea[9:2]];
                    wr = 1;
                    if (f3 == 0 || f3 == 4) begin
                        v = int'((w >> (8 * ea[1:0])) & 32'hff);
                        if (f3 == 0 && v > 127) v -= 256;
                        res = v;
                    end else if (f3 == 1 || f3 == 5) begin
                        v = int'((w >> (16 * ea[1])) & 32'hffff);
                        if (f3 == 1 && v > 32767) v -= 65536;
                        res = v;
                    end else if (f3 == 2) res = w;
                    else wr = 0;
                end
                'h23: begin
                    ea = a + is_; e_addr = ea;
                    if (f3 == 0) begin e_wen = 4'b0001 << ea[1:0]; e_wdata = {4{b[7:0]}}; end
                    if (f3 == 1) begin e_wen = ea[1] ? 4'b1100 : 4'b0011; e_wdata = {2{b[15:0]}}; end
                    if (f3 == 2) begin e_wen = 4'b1111; e_wdata = b; end
                    for (int k = 0; k < 4; k++)
                        if (e_wen[k]) m_dmem[ea[9:2]][8*k +: 8] = e_wdata[8*k +: 8];
                end
                'h13, 'h33: begin
                    if (op == 'h13) b = ii;
                    wr = 1;
                    if (op == 'h13 && f3 == 1 && f7 != 0) wr = 0;
                    if (op == 'h13 && f3 == 5 && f7 != 0 && f7 != 'h20) wr = 0;
                    if (op == 'h33 && f7 != 0 && !(f7 == 'h20 && (f3 == 0 || f3 == 5)) && f7 != 1) wr = 0;
                    if (op == 'h33 && f7 == 1) begin
                        wr = MUL_ON && f3 < 4;
                        if (f3 == 0) p = longint'(a) * longint'(b);
                        else if (f3 == 1) p = longint'(int'(a)) * longint'(int'(b));
                        else if (f3 == 2) p = longint'(int'(a)) * longint'({32'b0, b});
                        else p = longint'({32'b0, a}) * longint'({32'b0, b});
                        res = (f3 == 0) ? p[31:0] : p[63:32];
                    end else begin
                        case (f3)
                            0: res = (op == 'h33 && f7 == 'h20) ? a - b : a + b;
                            1: res = a << b[4:0];
                            2: res = (int'(a) < int'(b)) ? 1 : 0;
                            3: res = (a < b) ? 1 : 0;
                            4: res = a ^ b;
                            5: res = (f7 == 'h20) ? 32'(int'(a) >>> b[4:0]) : a >> b[4:0];
                            6: res = a | b;
                            default: res = a & b;
                        endcase
                    end
                end
                default: wr = 0;
            endcase
        end
        if (wr && rd != 0) m_regs[rd] = res;
        m_pc = nxt;
    endtask

    function automatic logic [31:0] gen_instr();
        int sel, f3, imm, r;
        sel = $urandom_range(0, 9);
        f3  = $urandom_range(0, 7);
        case (sel)
            0, 1, 2: begin
                imm = $urandom_range(0, 4095);
                if (f3 == 1) imm = imm & 31;
                if (f3 == 5) imm = (imm & 31) | ($urandom_range(0, 1) ? 'h400 : 0);
                return ins_i(7'h13, f3, $urandom_range(0, 31), $urandom_range(0, 31), imm);
            end
            3, 4: begin
                r = $urandom_range(0, 2);
                return ins_r(f3, (r == 1 && (f3 == 0 || f3 == 5)) ? 'h20 : (r == 2 ? 1 : 0),
                             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            end
            5: return ins_u($urandom_range(0, 1) ? 'h37 : 'h17, $urandom_range(0, 31), $urandom_range(0, 'hfffff));
            6: begin
                r = $urandom_range(0, 4);
                return ins_i(7'h03, (r == 3) ? 4 : (r == 4 ? 5 : r), $urandom_range(0, 31), 0, $urandom_range(0, 63));
            end
            7: return ins_s($urandom_range(0, 2), 0, $urandom_range(0, 31), $urandom_range(0, 63));
            8: begin
                r = $urandom_range(0, 5);
                return ins_b((r < 2) ? r : r + 2, $urandom_range(0, 31), $urandom_range(0, 31),
                             $urandom_range(1, 2) * 4);
            end
            default: begin
                r = $urandom_range(0, 3);
                if (r == 0) return ins_j($urandom_range(0, 31), 8);
                if (r == 1) return FILL;
                if (r == 2) return 32'h0000_000f;
                return 32'h0000_0073;
            end
        endcase
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] instr;
        int          chk_reg;   // -1: no register check
        logic [31:0] exp_val;
        logic [3:0]  exp_wen;
        logic [31:0] exp_wdata;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [31:0] ins, input int r, input logic [31:0] v,
                       input logic [3:0] wen, input logic [31:0] wd);
        vec_t e;
        e.instr = ins; e.chk_reg = r; e.exp_val = v; e.exp_wen = wen; e.exp_wdata = wd;
        tbl.push_back(e);
    endtask

    logic [3:0]  e_wen;
    logic [31:0] e_wdata, e_addr, ins;
    int          exp_pcs [8] = '{0, 4, 8, 16, 24, 32, 40, 44};
    int          cyc;

    initial begin
        add(addi(5, 0, 7),               5,  32'd7,                        4'b0, 0);
        add(addi(6, 0, 6),               6,  32'd6,                        4'b0, 0);
        add(ins_r(0, 1, 7, 5, 6),        7,  MUL_ON ? 32'd42 : 32'd0,      4'b0, 0);
        add(addi(5, 0, -5),              5,  32'hffff_fffb,                4'b0, 0);
        add(addi(6, 0, 3),               6,  32'd3,                        4'b0, 0);
        add(ins_r(0, 1, 8, 5, 6),        8,  MUL_ON ? 32'hffff_fff1 : 0,   4'b0, 0);
        add(ins_r(1, 1, 9, 5, 6),        9,  MUL_ON ? 32'hffff_ffff : 0,   4'b0, 0);
        add(ins_r(3, 1, 10, 5, 6),       10, MUL_ON ? 32'd2 : 32'd0,       4'b0, 0);
        add(ins_u('h37, 11, 'h10),       11, 32'h0001_0000,                4'b0, 0);
        add(ins_r(0, 1, 13, 11, 11),     13, 32'd0,                        4'b0, 0);
        add(ins_r(3, 1, 14, 11, 11),     14, MUL_ON ? 32'd1 : 32'd0,       4'b0, 0);
        add(ins_r(5, 1, 15, 5, 6),       15, 32'd0,                        4'b0, 0);
        add(addi(7, 0, 42),              7,  32'd42,                       4'b0, 0);
        add(ins_s(2, 0, 7, 0),           -1, 0,                            4'b1111, 32'd42);
        add(ins_i(3, 2, 17, 0, 0),       17, 32'd42,                       4'b0, 0);
        add(addi(18, 0, 'h80),           18, 32'h80,                       4'b0, 0);
        add(ins_s(0, 0, 18, 1),          -1, 0,                            4'b0010, 32'h8080_8080);
        add(ins_i(3, 0, 19, 0, 1),       19, 32'hffff_ff80,                4'b0, 0);
        add(ins_i(3, 4, 20, 0, 1),       20, 32'h0000_0080,                4'b0, 0);
        add(ins_i(3, 1, 21, 0, 0),       21, 32'hffff_802a,                4'b0, 0);
        add(ins_s(1, 0, 5, 2),           -1, 0,                            4'b1100, 32'hfffb_fffb);
        add(ins_i(3, 2, 22, 0, 0),       22, 32'hfffb_802a,                4'b0, 0);
        add(ins_i(3, 5, 23, 0, 3),       23, 32'h0000_fffb,                4'b0, 0);
        add(ins_i(7'h13, 5, 24, 5, 'h401), 24, 32'hffff_fffd,              4'b0, 0);
        add(ins_i(7'h13, 5, 25, 5, 28),  25, 32'h0000_000f,                4'b0, 0);
        add(ins_r(3, 0, 26, 6, 5),       26, 32'd1,                        4'b0, 0);
        add(ins_r(2, 0, 27, 5, 6),       27, 32'd1,                        4'b0, 0);
        add(ins_r(0, 'h20, 28, 6, 5),    28, 32'd8,                        4'b0, 0);
        add(ins_r(1, 0, 29, 6, 18),      29, 32'd3,                        4'b0, 0);
        add(32'h0000_0073,               29, 32'd3,                        4'b0, 0);
        add(FILL,                        29, 32'd3,                        4'b0, 0);
        add(32'h0000_000f,               -1, 0,                            4'b0, 0);

        // ---- directed table ----
        for (int i = 0; i < 256; i++) begin imem[i] = NOP; dmem[i] = '0; end
        for (int i = 0; i < tbl.size(); i++) imem[i] = tbl[i].instr;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            check32($sformatf("tbl_pc[%0d]", i), i_mem_addr, 32'(i * 4));
            check32($sformatf("tbl_wen[%0d]", i), {28'b0, d_mem_wen}, {28'b0, tbl[i].exp_wen});
            if (tbl[i].exp_wen != 4'b0)
                check32($sformatf("tbl_wdata[%0d]", i), d_mem_wdata, tbl[i].exp_wdata);
            @(posedge clk); #1;
            if (tbl[i].chk_reg >= 0)
                check32($sformatf("tbl_x%0d[%0d]", tbl[i].chk_reg, i), dut_reg(tbl[i].chk_reg), tbl[i].exp_val);
            @(negedge clk);
        end

        // ---- branch / jump sequence, then reset mid-program ----
        for (int i = 0; i < 256; i++) begin imem[i] = NOP; dmem[i] = '0; end
        imem[0]  = addi(1, 0, 5);         imem[1]  = addi(2, 0, 5);
        imem[2]  = ins_b(0, 1, 2, 8);     imem[3]  = addi(3, 0, 99);
        imem[4]  = ins_j(1, 8);           imem[5]  = addi(4, 0, 77);
        imem[6]  = ins_b(1, 1, 2, 8);     imem[7]  = addi(4, 0, 55);
        imem[8]  = ins_i(7'h67, 0, 6, 0, 41); imem[9] = addi(4, 0, 11);
        imem[10] = FILL;                  imem[11] = addi(9, 0, 1);
        imem[12] = ins_s(2, 0, 9, 4);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            check32($sformatf("br_pc[%0d]", k), i_mem_addr, 32'(exp_pcs[k]));
            @(posedge clk); #1;
            @(negedge clk);
        end
        check32("br_pc_end", i_mem_addr, 32'd48);
        check32("br_x1", dut_reg(1), 32'd20);
        check32("br_x3", dut_reg(3), 32'd0);
        check32("br_x4", dut_reg(4), 32'd0);
        check32("br_x6", dut_reg(6), 32'd36);
        check32("br_x9", dut_reg(9), 32'd1);
        check32("br_x29", dut_reg(29), 32'd0);
        check32("mid_wen_live", {28'b0, d_mem_wen}, 32'hf);
        rst_n = 1'b0;
        #1;
        check32("mid_wen_rst", {28'b0, d_mem_wen}, 32'h0);
        @(posedge clk); #1;
        check32("mid_pc", i_mem_addr, 32'd0);
        check_flat("mid_regs", dut.regs_flat, '0);
        check32("mid_dmem1", dmem[1], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check32("mid_fetch", i_mem_addr, RESET_PC);

        // ---- random program against the reference model ----
        for (int i = 0; i < 256; i++) begin imem[i] = NOP; dmem[i] = '0; m_dmem[i] = '0; end
        for (int i = 0; i < RN; i++) imem[i] = gen_instr();
        do_reset();
        m_pc = RESET_PC;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        cyc = 0;
        while (m_pc < 32'(4 * RN) && cyc < 2000) begin
            ins = imem[m_pc[9:2]];
            model_step(ins, e_wen, e_wdata, e_addr);
            check32($sformatf("rnd_wen[%0d]", cyc), {28'b0, d_mem_wen}, {28'b0, e_wen});
            if (e_wen != 4'b0) begin
                check32($sformatf("rnd_addr[%0d]", cyc), d_mem_addr, e_addr);
                check32($sformatf("rnd_wdata[%0d]", cyc), d_mem_wdata, e_wdata);
            end
            @(posedge clk); #1;
            check32($sformatf("rnd_pc[%0d] ins %h", cyc, ins), i_mem_addr, m_pc);
            check_flat($sformatf("rnd_regs[%0d] ins %h", cyc, ins), dut.regs_flat, model_flat());
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) begin
            n_vec++; n_fail++;
            $display("FAIL rnd_budget: got %0d cycles expected fewer than 2000", cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
